// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enable dual-port RAM: clear FSM encoding,
// byte merge helper and parameter legality check.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } clr_state_t;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

  function automatic bit params_ok(input int data_width,
                                   input int read_reg,
                                   input int rdw_new);
    return (data_width > 0) && (data_width % 8 == 0) &&
           (read_reg == 0 || read_reg == 1) &&
           (rdw_new == 0 || rdw_new == 1);
  endfunction

endpackage

// File: rtl/ram_2ports_be_if.sv
// Bus bundle for ram_2ports_be: clear control, byte-enable write port and read port.
interface ram_2ports_be_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  clear_req;
  logic                  busy;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BE_WIDTH-1:0]   w_be;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  wr_drop;
  logic                  r_en;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  modport master (
    output clear_req, write_en, w_addr, w_be, w_data, r_en, r_addr,
    input  busy, wr_drop, r_data, r_valid
  );

  modport slave (
    input  clear_req, write_en, w_addr, w_be, w_data, r_en, r_addr,
    output busy, wr_drop, r_data, r_valid
  );

endinterface

// File: rtl/ram_clear_ctrl.sv
// Clear engine: walks every address once after reset or clear_req.
//   state    | meaning
//   ST_CLEAR | writing INIT_VALUE to mem[clr_addr], user port locked out
//   ST_IDLE  | normal operation, user reads/writes accepted
module ram_clear_ctrl
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_t state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == LAST_ADDR) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
          end
        end
        default: begin
          state    <= ST_CLEAR;
          clr_addr <= '0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we = busy;

endmodule

// File: rtl/ram_2ports_be.sv
// Dual-port RAM with byte-enable writes, selectable read latency and
// read-during-write policy, plus a clear engine filling INIT_VALUE.
module ram_2ports_be
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 3,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    READ_REG   = 1,
  parameter int                    RDW_NEW    = 1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input logic            clk,
  input logic            rst_n,
  ram_2ports_be_if.slave bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH    = 1 << ADDR_WIDTH;

  if (!params_ok(DATA_WIDTH, READ_REG, RDW_NEW)) begin : g_param_err
    $error("ram_2ports_be: illegal DATA_WIDTH/READ_REG/RDW_NEW");
  end

  logic                  busy;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  user_we;
  logic                  rd_acc;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_raw;
  logic [DATA_WIDTH-1:0] rd_sel;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  ram_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (bus.clear_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign user_we     = bus.write_en & ~busy;
  assign rd_acc      = bus.r_en & ~busy;
  assign bus.busy    = busy;
  assign bus.wr_drop = bus.write_en & busy;

  assign wr_old = mem[bus.w_addr];

  for (genvar i = 0; i < BE_WIDTH; i++) begin : g_merge
    assign wr_merged[8*i +: 8] = merge_byte(wr_old[8*i +: 8], bus.w_data[8*i +: 8], bus.w_be[i]);
  end

  // The clear engine owns the write port whenever it runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VALUE;
    end else if (user_we) begin
      mem[bus.w_addr] <= wr_merged;
    end
  end

  assign rd_raw = mem[bus.r_addr];
  assign rd_sel = (RDW_NEW == 1 && user_we && bus.w_addr == bus.r_addr) ? wr_merged : rd_raw;

  if (READ_REG == 1) begin : g_rd_reg
    logic [DATA_WIDTH-1:0] r_data_q;
    logic                  r_valid_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_data_q  <= '0;
        r_valid_q <= 1'b0;
      end else begin
        r_valid_q <= rd_acc;
        if (rd_acc) begin
          r_data_q <= rd_sel;
        end
      end
    end

    assign bus.r_data  = r_data_q;
    assign bus.r_valid = r_valid_q;
  end else begin : g_rd_comb
    assign bus.r_data  = rd_sel;
    assign bus.r_valid = rd_acc;
  end

endmodule

// File: tb/tb_ram_2ports_be.sv
// Scoreboard bench for ram_2ports_be: three builds (registered/new, registered/old,
// combinational/new) share one stimulus stream; a negedge monitor checks read data.
module tb_ram_2ports_be;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_req;
  logic        write_en;
  logic [2:0]  w_addr;
  logic [1:0]  w_be;
  logic [15:0] w_data;
  logic        r_en;
  logic [2:0]  r_addr;

  int tests = 0;
  int fails = 0;

  // index 0: READ_REG=1/RDW_NEW=1, 1: READ_REG=1/RDW_NEW=0, 2: READ_REG=0/RDW_NEW=1
  logic [15:0] exp_q [3][$];

  always #5 clk = ~clk;

  ram_2ports_be_if #(.ADDR_WIDTH(3), .DATA_WIDTH(16)) ifa ();
  ram_2ports_be_if #(.ADDR_WIDTH(3), .DATA_WIDTH(16)) ifb ();
  ram_2ports_be_if #(.ADDR_WIDTH(3), .DATA_WIDTH(16)) ifc ();

  assign ifa.clear_req = clear_req;
  assign ifa.write_en  = write_en;
  assign ifa.w_addr    = w_addr;
  assign ifa.w_be      = w_be;
  assign ifa.w_data    = w_data;
  assign ifa.r_en      = r_en;
  assign ifa.r_addr    = r_addr;
  assign ifb.clear_req = clear_req;
  assign ifb.write_en  = write_en;
  assign ifb.w_addr    = w_addr;
  assign ifb.w_be      = w_be;
  assign ifb.w_data    = w_data;
  assign ifb.r_en      = r_en;
  assign ifb.r_addr    = r_addr;
  assign ifc.clear_req = clear_req;
  assign ifc.write_en  = write_en;
  assign ifc.w_addr    = w_addr;
  assign ifc.w_be      = w_be;
  assign ifc.w_data    = w_data;
  assign ifc.r_en      = r_en;
  assign ifc.r_addr    = r_addr;

  ram_2ports_be #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .READ_REG(1), .RDW_NEW(1),
                  .INIT_VALUE(16'h0000)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  ram_2ports_be #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .READ_REG(1), .RDW_NEW(0),
                  .INIT_VALUE(16'h0000)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  ram_2ports_be #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .READ_REG(0), .RDW_NEW(1),
                  .INIT_VALUE(16'h0000)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon_one(input int k, input logic v, input logic [15:0] d);
    if (v === 1'b1) begin
      if (exp_q[k].size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rdata_%0d: r_valid with no read pending, got %h expected none", k, d);
      end else begin
        check($sformatf("rdata_%0d", k), {16'h0, d}, {16'h0, exp_q[k].pop_front()});
      end
    end
  endtask

  always @(negedge clk) begin
    mon_one(0, ifa.r_valid, ifa.r_data);
    mon_one(1, ifb.r_valid, ifb.r_data);
    mon_one(2, ifc.r_valid, ifc.r_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rd(input logic [15:0] e_new, input logic [15:0] e_old);
    exp_q[0].push_back(e_new);
    exp_q[1].push_back(e_old);
    exp_q[2].push_back(e_new);
  endtask

  task automatic do_read(input logic [2:0] a, input logic [15:0] e);
    r_en   = 1'b1;
    r_addr = a;
    push_rd(e, e);
    step();
    r_en = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [1:0] be, input logic [15:0] d);
    write_en = 1'b1;
    w_addr   = a;
    w_be     = be;
    w_data   = d;
    step();
    write_en = 1'b0;
  endtask

  task automatic do_rdw(input logic [1:0] be, input logic [15:0] d,
                        input logic [15:0] e_new, input logic [15:0] e_old);
    write_en = 1'b1;
    w_addr   = 3'd5;
    w_be     = be;
    w_data   = d;
    r_en     = 1'b1;
    r_addr   = 3'd5;
    push_rd(e_new, e_old);
    step();
    write_en = 1'b0;
    r_en     = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (ifa.busy === 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; clear_req = 1'b0; write_en = 1'b0; w_addr = '0; w_be = '0;
    w_data = '0; r_en = 1'b0; r_addr = '0;
    repeat (3) step();

    check("reset_busy_a", {31'h0, ifa.busy}, 32'd1);
    check("reset_busy_c", {31'h0, ifc.busy}, 32'd1);
    check("reset_rvalid_a", {31'h0, ifa.r_valid}, 32'd0);
    check("reset_rdata_a", {16'h0, ifa.r_data}, 32'h0);
    check("reset_rvalid_c", {31'h0, ifc.r_valid}, 32'd0);

    // initial clear; a write lands in clear cycle 4 and must be dropped
    rst_n = 1'b1;
    n = 0;
    while (ifa.busy === 1'b1 && n < 40) begin
      if (n == 4) begin
        write_en = 1'b1; w_addr = 3'd2; w_be = 2'b11; w_data = 16'hFFFF;
        #1;
        check("wr_drop_busy", {31'h0, ifa.wr_drop}, 32'd1);
      end else begin
        write_en = 1'b0;
      end
      step();
      n++;
    end
    write_en = 1'b0;
    check("init_clear_len", n, 32'd8);
    check("idle_busy_c", {31'h0, ifc.busy}, 32'd0);

    for (int i = 0; i < 8; i++) do_read(3'(i), 16'h0000);
    step();

    do_write(3'd3, 2'b11, 16'hABCD);
    do_write(3'd3, 2'b01, 16'h1234);
    do_read(3'd3, 16'hAB34);
    step();
    check("rvalid_drop_a", {31'h0, ifa.r_valid}, 32'd0);
    check("rdata_hold_a", {16'h0, ifa.r_data}, 32'h0000AB34);

    do_write(3'd5, 2'b11, 16'h1111);
    do_rdw(2'b11, 16'h2222, 16'h2222, 16'h1111);
    do_read(3'd5, 16'h2222);
    do_rdw(2'b10, 16'h3344, 16'h3322, 16'h2222);
    do_read(3'd5, 16'h3322);
    do_write(3'd5, 2'b00, 16'hFFFF);
    do_read(3'd5, 16'h3322);

    for (int i = 0; i < 8; i++) do_write(3'(i), 2'b11, 16'h5A5A);
    do_read(3'd6, 16'h5A5A);

    // clear_req with a simultaneous write; second request and a read mid-clear
    clear_req = 1'b1; write_en = 1'b1; w_addr = 3'd7; w_be = 2'b11; w_data = 16'h1111;
    #1;
    check("wr_drop_idle", {31'h0, ifa.wr_drop}, 32'd0);
    step();
    clear_req = 1'b0; write_en = 1'b0;
    check("clear_busy", {31'h0, ifa.busy}, 32'd1);
    n = 0;
    while (ifa.busy === 1'b1 && n < 40) begin
      r_en      = (n == 2);
      r_addr    = 3'd0;
      clear_req = (n == 3);
      step();
      n++;
    end
    r_en = 1'b0; clear_req = 1'b0;
    check("req_clear_len", n, 32'd8);
    for (int i = 0; i < 8; i++) do_read(3'(i), 16'h0000);

    // reset asserted mid-clear restarts the sweep from address 0
    do_write(3'd7, 2'b11, 16'h7777);
    do_read(3'd7, 16'h7777);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_busy", {31'h0, ifa.busy}, 32'd1);
    wait_idle(n);
    check("rst_mid_clear_len", n, 32'd8);
    do_read(3'd7, 16'h0000);
    do_read(3'd4, 16'h0000);

    repeat (3) step();
    check("queue_drain", exp_q[0].size() + exp_q[1].size() + exp_q[2].size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
